mem_access_stage: RTL

Memory stage plus MEM/WB pipeline register for the 5-stage 16-bit pipeline. It issues loads and stores to a variable-latency data memory through a req/done handshake and stalls upstream stages while an access is outstanding. It registers the load data, ALU result, link PC and writeback controls consumed by the writeback stage. Bubbles are inserted toward writeback during stalls.

---
 rtl/wisc_pkg.sv | 26 ++
 rtl/mem_wb_reg.sv | 27 ++
 rtl/mem_access_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, memory-stage FSM encoding
// and the MEM/WB field bundle consumed by the writeback stage.
package wisc_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic              memToReg;
        logic              writeR7;
        logic              writeEn;
        logic              halt;
        logic              err;
        logic [DATA_W-1:0] readData;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] nextPC;
        logic [REG_W-1:0]  writeRegSel;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble request loads an all-zero (invalid) bundle.
module mem_wb_reg
    import wisc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t q_q;

    // MEM/WB bundle register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (bubble) begin
            q_q <= '0;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory accesses over a req/done handshake, stalls the
// front of the pipe while an access is outstanding, and feeds the MEM/WB register.
module mem_access_stage
    import wisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] storeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [DATA_W-1:0] nextPC,
    input  logic              memToReg,
    input  logic              writeR7,
    input  logic              writeEn,
    input  logic              halt,
    input  logic [REG_W-1:0]  writeRegSel,
    output logic              dmem_req,
    output logic              dmem_wr,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_done,
    input  logic              dmem_err,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_memToReg,
    output logic              wb_writeR7,
    output logic              wb_writeEn,
    output logic              wb_halt,
    output logic              wb_err,
    output logic [DATA_W-1:0] wb_readData,
    output logic [DATA_W-1:0] wb_aluResult,
    output logic [DATA_W-1:0] wb_nextPC,
    output logic [REG_W-1:0]  wb_writeRegSel,
    output logic [15:0]       stall_cycles
);

    mem_state_e state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_op_s, unaligned_s, issue_s, is_load_s, done_ok_s, err_s;
    mem_wb_t     wb_d, wb_q;

    assign mem_op_s    = in_valid & (memRead | memWrite);
    assign unaligned_s = aluResult[0];
    assign issue_s     = mem_op_s & ~unaligned_s;
    assign is_load_s   = memRead & ~memWrite;
    assign done_ok_s   = dmem_req & dmem_done;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (issue_s && !dmem_done) ? BUSY : IDLE;
            BUSY:    state_d = dmem_done ? IDLE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; reset kills the request in the same cycle it asserts
    always_comb begin
        dmem_req = 1'b0;
        case (state_q)
            IDLE:    dmem_req = ~rst & issue_s;
            BUSY:    dmem_req = ~rst;
            default: dmem_req = 1'b0;
        endcase
        stall = dmem_req & ~dmem_done;
    end

    assign dmem_wr    = dmem_req & memWrite;
    assign dmem_addr  = aluResult;
    assign dmem_wdata = storeData;

    // MEM/WB bundle assembly with error and valid gating
    always_comb begin
        err_s            = mem_op_s & (unaligned_s | (done_ok_s & dmem_err));
        wb_d             = '0;
        wb_d.valid       = in_valid;
        wb_d.memToReg    = memToReg & in_valid;
        wb_d.writeR7     = writeR7 & in_valid;
        wb_d.writeEn     = writeEn & in_valid & ~err_s;
        wb_d.halt        = halt & in_valid;
        wb_d.err         = err_s;
        wb_d.readData    = (mem_op_s && is_load_s && done_ok_s) ? dmem_rdata : {DATA_W{1'b0}};
        wb_d.aluResult   = aluResult;
        wb_d.nextPC      = nextPC;
        wb_d.writeRegSel = writeRegSel;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .bubble (stall),
        .d      (wb_d),
        .q      (wb_q)
    );

    // Saturating stall-cycle counter next state
    always_comb begin
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles   = stall_cnt_q;
    assign wb_valid       = wb_q.valid;
    assign wb_memToReg    = wb_q.memToReg;
    assign wb_writeR7     = wb_q.writeR7;
    assign wb_writeEn     = wb_q.writeEn;
    assign wb_halt        = wb_q.halt;
    assign wb_err         = wb_q.err;
    assign wb_readData    = wb_q.readData;
    assign wb_aluResult   = wb_q.aluResult;
    assign wb_nextPC      = wb_q.nextPC;
    assign wb_writeRegSel = wb_q.writeRegSel;

endmodule
